hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage CPU (IF/ID/EX/MEM/WR).
//  Drives PC and pipeline-register write enables, flushes and bubbles.
//  Handles three hazard types: load-use stalls, taken-branch flushes and
//  multi-cycle mul/div occupancy of EX.
//  Companion to the EX-stage forwarding units, covering hazards they cannot resolve.
// PARAMETERS
//  LOAD_STALL  1   load-use stall length in cycles; legal range 1..3
//  CNT_W       16  width of the saturating stall-cycle counter
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      synchronous reset, active-high
//  rs_ID         in   5      rs field of the instruction in ID
//  rt_ID         in   5      rt field of the instruction in ID
//  use_rs_ID     in   1      ID instruction reads rs
//  use_rt_ID     in   1      ID instruction reads rt
//  MemRead_EX    in   1      instruction in EX is a load
//  rw_EX         in   5      destination register of the EX instruction
//  Branch_EX     in   1      branch/jump resolved taken in EX
//  md_start_EX   in   1      mul/div instruction in EX; first cycle only
//  md_done       in   1      mul/div result valid this cycle
//  PC_Write      out  1      PC register update enable
//  IF_ID_Write   out  1      IF/ID register write enable
//  IF_ID_Flush   out  1      zero the IF/ID register (becomes nop)
//  ID_EX_Write   out  1      ID/EX register write enable
//  ID_EX_Flush   out  1      load a bubble into ID/EX
//  EX_MEM_Bubble out  1      load a bubble into EX/MEM
//  stall_cnt     out  CNT_W  count of cycles with PC_Write==0; saturating
// BEHAVIOUR
//  Registered state: st in {RUN, LSTALL, MDWAIT}; cnt[1:0]; stall_cnt.
//  Outputs are combinational from st and inputs (Mealy).
//  rst=1: next st=RUN, cnt=0, stall_cnt=0. While rst=1, all outputs are 0
//    (pipeline frozen), regardless of the current state (mid-stall or mid-md).
//  Default outputs: PC_Write=IF_ID_Write=ID_EX_Write=1; flush and bubble outputs=0.
//  luse = MemRead_EX & rw_EX!=0 &
//    ((use_rs_ID & rw_EX==rs_ID) | (use_rt_ID & rw_EX==rt_ID))
//  RUN, priority order:
//   1 Branch_EX: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1. Stay in RUN.
//     Branch takes priority over luse and md_start_EX (wrong-path instructions).
//   2 md_start_EX:
//     - if md_done: default outputs; stay in RUN.
//     - else: PC_Write=IF_ID_Write=ID_EX_Write=0, EX_MEM_Bubble=1;
//       next st=MDWAIT.
//   3 luse: PC_Write=IF_ID_Write=0, ID_EX_Flush=1.
//     If LOAD_STALL>1: next st=LSTALL, cnt=LOAD_STALL-1. Otherwise stay in RUN.
//   4 otherwise: default outputs.
//  LSTALL: PC_Write=IF_ID_Write=0, ID_EX_Flush=1; cnt decrements each cycle;
//    when cnt==1, next st=RUN. Branch_EX and md_start_EX are ignored
//    (EX holds a bubble).
//  MDWAIT: PC_Write=IF_ID_Write=ID_EX_Write=0, EX_MEM_Bubble=1 until md_done.
//    In the md_done cycle: default outputs (result latches into EX/MEM);
//    next st=RUN. No timeout.
//  stall_cnt increments on each non-reset cycle with PC_Write==0;
//    holds at 2^CNT_W-1 (no wrap).
//  Total stall per load-use hazard = LOAD_STALL cycles.
//  Total stall per mul/div = cycles from md_start_EX to md_done, exclusive.
// TESTING
//  T1 lw $3 then add $4,$3,$5, LOAD_STALL=1 -> one cycle PC_Write=0,
//     ID_EX_Flush=1; st stays RUN; stall_cnt=1.
//  T2 same stimulus, LOAD_STALL=3 -> 3 consecutive stall cycles, then RUN;
//     stall_cnt=3. rw_EX=0 with rs_ID=0 -> no stall.
//  T3 Branch_EX=1 and luse=1 in the same cycle -> IF_ID_Flush=ID_EX_Flush=1,
//     PC_Write=1; no stall; stall_cnt unchanged.
//  T4 md_start_EX, md_done 4 cycles later -> 4 cycles frozen with
//     EX_MEM_Bubble=1; done cycle shows defaults; md_start with md_done in
//     the same cycle -> no stall.
//  T5 rst pulse during MDWAIT and during LSTALL -> outputs 0 while rst=1;
//     next cycle st=RUN, defaults, stall_cnt=0.
//  T6 CNT_W=4, 20 stall cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline sequencing controller for load-use, branch and mul/div hazards
module hazard_ctrl #(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             use_rs_ID,
    input  logic             use_rt_ID,
    input  logic             MemRead_EX,
    input  logic [4:0]       rw_EX,
    input  logic             Branch_EX,
    input  logic             md_start_EX,
    input  logic             md_done,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Bubble,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MDWAIT = 2'd2
    } st_t;

    // Cycles still to be spent in LSTALL after the first stall cycle in RUN.
    localparam logic [1:0] LS_EXTRA = 2'(LOAD_STALL - 1);

    st_t        st, st_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       luse;

    // Load in EX writes a register the ID instruction reads; $0 never hazards.
    always_comb begin
        luse = MemRead_EX && (rw_EX != 5'd0) &&
               ((use_rs_ID && (rw_EX == rs_ID)) || (use_rt_ID && (rw_EX == rt_ID)));
    end

    // State register, stall-length counter and saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= RUN;
            cnt       <= 2'd0;
            stall_cnt <= '0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
            if (!PC_Write && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Next-state logic; branch outranks mul/div which outranks load-use.
    always_comb begin
        st_nxt  = st;
        cnt_nxt = cnt;
        case (st)
            RUN: begin
                if (Branch_EX) begin
                    st_nxt = RUN;
                end else if (md_start_EX) begin
                    if (!md_done)
                        st_nxt = MDWAIT;
                end else if (luse && (LOAD_STALL > 1)) begin
                    st_nxt  = LSTALL;
                    cnt_nxt = LS_EXTRA;
                end
            end
            LSTALL: begin
                // EX holds a bubble here, so branch and mul/div inputs are irrelevant.
                cnt_nxt = cnt - 2'd1;
                if (cnt == 2'd1)
                    st_nxt = RUN;
            end
            MDWAIT: begin
                if (md_done)
                    st_nxt = RUN;
            end
            default: begin
                st_nxt  = RUN;
                cnt_nxt = 2'd0;
            end
        endcase
    end

    // Mealy outputs; reset freezes the whole pipeline regardless of state.
    always_comb begin
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Write   = 1'b1;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Bubble = 1'b0;
        if (rst) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Write = 1'b0;
        end else begin
            case (st)
                RUN: begin
                    if (Branch_EX) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                    end else if (md_start_EX) begin
                        if (!md_done) begin
                            PC_Write      = 1'b0;
                            IF_ID_Write   = 1'b0;
                            ID_EX_Write   = 1'b0;
                            EX_MEM_Bubble = 1'b1;
                        end
                    end else if (luse) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end
                end
                LSTALL: begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                end
                MDWAIT: begin
                    // In the done cycle the result latches into EX/MEM normally.
                    if (!md_done) begin
                        PC_Write      = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_Write   = 1'b0;
                        EX_MEM_Bubble = 1'b1;
                    end
                end
                default: begin
                    PC_Write = 1'b1;
                end
            endcase
        end
    end

endmodule
